audio_out_stage: RTL and testbench

- Final audio stage between the console audio sources (TIA LUT output, cart POKEY, cart YM) and the framework audio output.
- Per channel: saturating 3-source mix, box-average decimation by DIV input strobes, first-order DC-blocking high-pass, signed 16-bit output with a one-cycle valid strobe.
- Replaces the wrapping unsigned sum at the console top level.
- Exposes a sticky clip flag for debug/OSD.

---
 rtl/audio_out_stage.sv | 140 ++++++++++++++
 tb/tb_audio_out_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_out_stage.sv
// Final console audio stage: saturating 3-source mix, box-average decimation,
// optional first-order DC-blocking high-pass, signed 16-bit stereo output.
module audio_out_stage #(
   parameter int unsigned DIV      = 16,
   parameter int unsigned DC_SHIFT = 10,
   parameter int unsigned DC_EN    = 1
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        ce_in,
   input  logic [15:0] tia_l,
   input  logic [15:0] tia_r,
   input  logic [15:0] pokey_l,
   input  logic [15:0] pokey_r,
   input  logic [15:0] ym_l,
   input  logic [15:0] ym_r,
   input  logic        mute,
   input  logic        clip_clr,
   output logic [15:0] out_l,
   output logic [15:0] out_r,
   output logic        out_valid,
   output logic        clip
);

   localparam int unsigned LOG2 = $clog2(DIV);
   localparam int unsigned CW   = (LOG2 == 0) ? 1 : LOG2;
   localparam int unsigned AW   = 16 + LOG2;

   function automatic logic [15:0] sat16(input logic signed [19:0] v);
      if (v > 20'sd32767)       return 16'h7FFF;
      else if (v < -20'sd32768) return 16'h8000;
      else                      return v[15:0];
   endfunction

   logic [17:0]          w_sum_l, w_sum_r;
   logic                 w_clip_l, w_clip_r;
   logic [15:0]          w_m_l, w_m_r;
   logic [AW-1:0]        w_acc_l, w_acc_r;
   logic                 w_last;

   logic [AW-1:0]        r_acc_l, r_acc_r;
   logic [CW-1:0]        r_cnt;
   logic [15:0]          r_avg_l, r_avg_r;
   logic                 r_avg_stb;

   logic signed [16:0]   w_x_l, w_x_r;
   logic signed [19:0]   w_y_l, w_y_r;
   logic [15:0]          w_flt_l, w_flt_r;
   logic [15:0]          w_raw_l, w_raw_r;
   logic [15:0]          w_res_l, w_res_r;
   logic signed [16:0]   r_xp_l, r_xp_r;
   logic signed [15:0]   r_yp_l, r_yp_r;

   // Mix with saturation, then running sum for the current decimation group
   always_comb begin
      w_sum_l  = 18'(tia_l) + 18'(pokey_l) + 18'(ym_l);
      w_sum_r  = 18'(tia_r) + 18'(pokey_r) + 18'(ym_r);
      w_clip_l = |w_sum_l[17:16];
      w_clip_r = |w_sum_r[17:16];
      w_m_l    = w_clip_l ? 16'hFFFF : w_sum_l[15:0];
      w_m_r    = w_clip_r ? 16'hFFFF : w_sum_r[15:0];
      w_acc_l  = r_acc_l + AW'(w_m_l);
      w_acc_r  = r_acc_r + AW'(w_m_r);
      w_last   = (r_cnt == CW'(DIV - 1));
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_acc_l   <= '0;
         r_acc_r   <= '0;
         r_cnt     <= '0;
         r_avg_l   <= '0;
         r_avg_r   <= '0;
         r_avg_stb <= 1'b0;
      end else begin
         r_avg_stb <= 1'b0;
         if (ce_in) begin
            if (w_last) begin
               r_avg_l   <= 16'(w_acc_l >> LOG2);
               r_avg_r   <= 16'(w_acc_r >> LOG2);
               r_acc_l   <= '0;
               r_acc_r   <= '0;
               r_cnt     <= '0;
               r_avg_stb <= 1'b1;
            end else begin
               r_acc_l <= w_acc_l;
               r_acc_r <= w_acc_r;
               r_cnt   <= r_cnt + CW'(1);
            end
         end
      end
   end

   // Sticky clip: a clipping strobe beats a simultaneous clear
   always_ff @(posedge clk_sys) begin
      if (rst)                              clip <= 1'b0;
      else if (ce_in && (w_clip_l || w_clip_r)) clip <= 1'b1;
      else if (clip_clr)                    clip <= 1'b0;
   end

   // DC blocker: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT)
   always_comb begin
      w_x_l   = signed'({1'b0, r_avg_l});
      w_x_r   = signed'({1'b0, r_avg_r});
      w_y_l   = 20'(w_x_l) - 20'(r_xp_l) + 20'(r_yp_l) - (20'(r_yp_l) >>> DC_SHIFT);
      w_y_r   = 20'(w_x_r) - 20'(r_xp_r) + 20'(r_yp_r) - (20'(r_yp_r) >>> DC_SHIFT);
      w_flt_l = sat16(w_y_l);
      w_flt_r = sat16(w_y_r);
      w_raw_l = sat16(20'(w_x_l) - 20'sd32768);
      w_raw_r = sat16(20'(w_x_r) - 20'sd32768);
      w_res_l = (DC_EN != 0) ? w_flt_l : w_raw_l;
      w_res_r = (DC_EN != 0) ? w_flt_r : w_raw_r;
   end

   // Mute only zeroes the output registers; filter history keeps advancing
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         out_l     <= '0;
         out_r     <= '0;
         out_valid <= 1'b0;
         r_xp_l    <= '0;
         r_xp_r    <= '0;
         r_yp_l    <= '0;
         r_yp_r    <= '0;
      end else begin
         out_valid <= r_avg_stb;
         if (r_avg_stb) begin
            out_l <= mute ? 16'h0000 : w_res_l;
            out_r <= mute ? 16'h0000 : w_res_r;
            if (DC_EN != 0) begin
               r_xp_l <= w_x_l;
               r_xp_r <= w_x_r;
               r_yp_l <= signed'(w_flt_l);
               r_yp_r <= signed'(w_flt_r);
            end
         end
      end
   end

endmodule

// File: tb/tb_audio_out_stage.sv
// Scoreboard bench for audio_out_stage: four instances cover DIV=1/4/16 and
// the DC blocker on/off; a monitor pops expected samples on out_valid.
module tb_audio_out_stage;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  ce_v = '0;
   logic [15:0] tl = '0, tr = '0, pl = '0, pr = '0, yl = '0, yr = '0;
   logic        mute = 1'b0;
   logic        clip_clr = 1'b0;
   logic [15:0] ol [4];
   logic [15:0] orr [4];
   logic        ov [4];
   logic        oc [4];

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      int          cyc;
   } exp_t;

   typedef struct {
      int   cyc;
      int   inst;
      bit   full;
      logic c;
   } snap_t;

   exp_t  q_out [4][$];
   snap_t q_snap[$];
   int    cyc = 0;
   int    errors = 0;
   int    checks = 0;
   bit    done = 1'b0;

   logic [15:0] exp3 [10] = '{16'h4000, 16'h3FF0, 16'h3FE1, 16'h0000, 16'h0000,
                              16'h0000, 16'h3FA5, 16'h3F96, 16'h3F87, 16'hFF78};

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   audio_out_stage #(.DIV(1), .DC_SHIFT(10), .DC_EN(0)) u_a (
      .clk_sys(clk_sys), .rst(rst), .ce_in(ce_v[0]),
      .tia_l(tl), .tia_r(tr), .pokey_l(pl), .pokey_r(pr), .ym_l(yl), .ym_r(yr),
      .mute(mute), .clip_clr(clip_clr),
      .out_l(ol[0]), .out_r(orr[0]), .out_valid(ov[0]), .clip(oc[0]));

   audio_out_stage #(.DIV(4), .DC_SHIFT(10), .DC_EN(0)) u_b (
      .clk_sys(clk_sys), .rst(rst), .ce_in(ce_v[1]),
      .tia_l(tl), .tia_r(tr), .pokey_l(pl), .pokey_r(pr), .ym_l(yl), .ym_r(yr),
      .mute(mute), .clip_clr(clip_clr),
      .out_l(ol[1]), .out_r(orr[1]), .out_valid(ov[1]), .clip(oc[1]));

   audio_out_stage #(.DIV(1), .DC_SHIFT(10), .DC_EN(1)) u_c (
      .clk_sys(clk_sys), .rst(rst), .ce_in(ce_v[2]),
      .tia_l(tl), .tia_r(tr), .pokey_l(pl), .pokey_r(pr), .ym_l(yl), .ym_r(yr),
      .mute(mute), .clip_clr(clip_clr),
      .out_l(ol[2]), .out_r(orr[2]), .out_valid(ov[2]), .clip(oc[2]));

   audio_out_stage #(.DIV(16), .DC_SHIFT(10), .DC_EN(0)) u_d (
      .clk_sys(clk_sys), .rst(rst), .ce_in(ce_v[3]),
      .tia_l(tl), .tia_r(tr), .pokey_l(pl), .pokey_r(pr), .ym_l(yl), .ym_r(yr),
      .mute(mute), .clip_clr(clip_clr),
      .out_l(ol[3]), .out_r(orr[3]), .out_valid(ov[3]), .clip(oc[3]));

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // One input strobe; output expected two cycles later, clip (instance 0) one cycle later
   task automatic strobe(input int inst,
                         input logic [15:0] a_l, input logic [15:0] b_l, input logic [15:0] c_l,
                         input logic [15:0] a_r, input logic [15:0] b_r, input logic [15:0] c_r,
                         input bit push, input logic [15:0] el, input logic [15:0] er,
                         input logic ec);
      tl = a_l; pl = b_l; yl = c_l;
      tr = a_r; pr = b_r; yr = c_r;
      ce_v[inst] = 1'b1;
      if (push) q_out[inst].push_back('{el, er, cyc + 2});
      if (inst == 0) q_snap.push_back('{cyc + 1, 0, 1'b0, ec});
      tick();
      ce_v = '0;
   endtask

   // Monitor: owns every comparison and the summary
   initial begin
      forever begin
         @(negedge clk_sys);
         if (done) break;
         for (int i = 0; i < 4; i++) begin
            if (ov[i] === 1'b1) begin
               checks++;
               if (q_out[i].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_valid inst=%0d cyc=%0d got l=%h r=%h, required no output",
                           i, cyc, ol[i], orr[i]);
               end else begin
                  exp_t e;
                  e = q_out[i].pop_front();
                  if (ol[i] !== e.l || orr[i] !== e.r || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL sample inst=%0d got l=%h r=%h cyc=%0d, required l=%h r=%h cyc=%0d",
                              i, ol[i], orr[i], cyc, e.l, e.r, e.cyc);
                  end
               end
            end
         end
         while (q_snap.size() > 0 && q_snap[0].cyc <= cyc) begin
            snap_t s;
            s = q_snap.pop_front();
            checks++;
            if (oc[s.inst] !== s.c ||
                (s.full && (ol[s.inst] !== 16'h0 || orr[s.inst] !== 16'h0 || ov[s.inst] !== 1'b0))) begin
               errors++;
               $display("FAIL state inst=%0d cyc=%0d got clip=%b l=%h r=%h v=%b, required clip=%b%s",
                        s.inst, cyc, oc[s.inst], ol[s.inst], orr[s.inst], ov[s.inst], s.c,
                        s.full ? " l=0 r=0 v=0" : "");
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q_out[i].size() != 0) begin
            errors++;
            $display("FAIL missing_output inst=%0d got %0d pending, required 0", i, q_out[i].size());
         end
      end
      checks++;
      if (q_snap.size() != 0) begin
         errors++;
         $display("FAIL pending_state got %0d pending, required 0", q_snap.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout, required end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state on all instances
      rst = 1'b1;
      tick(); tick();
      for (int i = 0; i < 4; i++) q_snap.push_back('{cyc + 1, i, 1'b1, 1'b0});
      tick();
      rst = 1'b0;
      tick();

      // DIV=1 raw: left clip, clear alone, right clip, sticky, set beats clear
      strobe(0, 16'h8000, 16'h9000, 16'h0000, 16'h0, 16'h0, 16'h0, 1'b1, 16'h7FFF, 16'h8000, 1'b1);
      clip_clr = 1'b1;
      q_snap.push_back('{cyc + 1, 0, 1'b0, 1'b0});
      tick();
      clip_clr = 1'b0;
      q_snap.push_back('{cyc + 1, 0, 1'b0, 1'b0});
      tick();
      strobe(0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
      strobe(0, 16'h1000, 16'h2000, 16'h3000, 16'h0, 16'h0, 16'h0, 1'b1, 16'hE000, 16'h8000, 1'b1);
      clip_clr = 1'b1;
      strobe(0, 16'h8000, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 1'b1, 16'h7FFF, 16'h8000, 1'b1);
      clip_clr = 1'b0;
      repeat (4) tick();

      // DIV=4 raw: average of 1000/2000/3000/4001, then full-scale with truncated remainder
      strobe(1, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
      strobe(1, 16'h2000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
      strobe(1, 16'h3000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
      strobe(1, 16'h4000, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 16'hA800, 16'h8000, 1'b0);
      repeat (3) tick();
      for (int k = 0; k < 4; k++)
         strobe(1, 16'hFFFF, 16'h0, 16'h0, (k == 3) ? 16'h2 : 16'h1, 16'h0, 16'h0,
                k == 3, 16'h7FFF, 16'h8001, 1'b0);
      repeat (4) tick();

      // DIV=1 DC blocker: decay, mute window keeps state advancing, then a step down
      for (int k = 0; k < 10; k++) begin
         mute = (k >= 3 && k <= 5);
         strobe(2, (k < 9) ? 16'h4000 : 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                1'b1, exp3[k], 16'h0000, 1'b0);
         tick(); tick();
      end
      mute = 1'b0;
      repeat (4) tick();

      // DIV=16: reset mid-group discards the partial sum and count
      for (int k = 0; k < 7; k++)
         strobe(3, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) q_snap.push_back('{cyc + 1, i, 1'b1, 1'b0});
      tick();
      rst = 1'b0;
      for (int k = 0; k < 16; k++)
         strobe(3, 16'h0100, 16'h0, 16'h0, 16'h0200, 16'h0, 16'h0,
                k == 15, 16'h8100, 16'h8200, 1'b0);
      repeat (6) tick();
      done = 1'b1;
   end

endmodule
